scratchpad_seq: RTL

Access sequencer for the 2 MiB CryptoNight scratchpad: 131072 words of 128 bits. It sits directly upstream of the `spram128k` scratchpad RAM and is the only block that drives its `re`/`we`/`addr`/`din` ports. It runs in two phases. In the fill phase it streams the initial scratchpad contents from the explode stage into sequential addresses. In the run phase it serves main-loop read and write requests over valid/ready handshakes and returns read data through a registered response slot.

---
 rtl/scratchpad_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/scratchpad_seq.sv
// scratchpad_seq: fill/run access sequencer that owns the CryptoNight scratchpad RAM port.
module scratchpad_seq #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 128,
    parameter int FILL_WORDS = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_fill,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_ready,
    output logic                  fill_done,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  rsp_ready,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(FILL_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
    state_t state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic pend_q, pend_d, rsp_valid_q, rsp_valid_d, fill_done_q, fill_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic fill_beat, req_acc, req_wr, refill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_fill ? FILL : IDLE;
            FILL:    state_d = (fill_beat && cnt_q == LAST) ? RUN : FILL;
            RUN:     state_d = refill ? FILL : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_ready = state_q == FILL;
        req_ready = state_q == RUN && !pend_q && (!rsp_valid_q || rsp_ready);
        fill_beat = fill_valid && fill_ready;
        req_acc = req_valid && req_ready;
        req_wr = req_acc && req_we;
        // a refill may only start once the pipeline is completely empty
        refill = state_q == RUN && start_fill && !pend_q && !rsp_valid_q && !req_acc;
        ram_we = fill_beat || req_wr;
        ram_re = req_acc && !req_we;
        ram_addr = fill_beat ? cnt_q[ADDR_WIDTH-1:0] : req_acc ? req_addr : '0;
        ram_din = fill_beat ? fill_data : req_wr ? req_wdata : '0;
    end

    always_comb begin
        cnt_d = (state_q != FILL && state_d == FILL) ? '0 : fill_beat ? cnt_q + ONE : cnt_q;
        pend_d = ram_re;
        rsp_valid_d = pend_q || (rsp_valid_q && !rsp_ready);
        rsp_rdata_d = pend_q ? ram_dout : rsp_rdata_q;
        fill_done_d = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pend_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            fill_done_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign fill_done = fill_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule
